bcd_counter_nd: RTL and testbench

- Parametrised N-digit BCD up/down counter with an internal tick prescaler, pause/resume, parallel load, wrap-or-saturate mode and a lap-freeze display register.
- Next-generation stopwatch/timer core for the SoC report designs.
- Feeds the seven-segment display multiplexer with both a live count and a display count.
- Replaces fixed 4-digit, up-only, clear-on-stop counting.

---
 rtl/bcd_counter_nd.sv | 198 +++++++++++++++++++
 tb/tb_bcd_counter_nd.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with tick prescaler, pause, parallel load,
// wrap-or-saturate terminal handling and a lap-freeze display register.
module bcd_counter_nd #(
  parameter int NDIG = 4,
  parameter int DVSR = 100000,
  parameter int WRAP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                clr,
  input  logic                up,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic                lap,
  output logic [4*NDIG-1:0]   count,
  output logic [4*NDIG-1:0]   disp,
  output logic                step,
  output logic                tc,
  output logic                wrap_p
);

  localparam int W  = 4 * NDIG;
  // A one-cycle prescaler still needs a 1-bit register to stay legal.
  localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(DVSR - 1);

  // Ripple increment: a 9 rolls to 0 and carries into the next digit.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!c) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Ripple decrement: a 0 rolls to 9 and borrows from the next digit.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (!b) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b = 1'b0;
      end
    end
    return r;
  endfunction

  // True when every digit of v equals d.
  function automatic logic all_digits(input logic [W-1:0] v, input logic [3:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] != d) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Non-BCD digits in a load value are forced to 9.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [PW-1:0] psc_q, psc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  snap_q, snap_d;
  logic          frozen_q, frozen_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic          tick_s;
  logic [W-1:0]  inc_s, dec_s;

  assign tick_s = go && (psc_q == PSC_MAX);
  assign inc_s  = bcd_inc(count_q);
  assign dec_s  = bcd_dec(count_q);

  // Next-state: clr beats load beats tick; lap toggles freeze using the updated count.
  always_comb begin
    psc_d    = psc_q;
    count_d  = count_q;
    frozen_d = frozen_q;
    snap_d   = snap_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    if (clr) begin
      count_d  = '0;
      psc_d    = '0;
      frozen_d = 1'b0;
    end else if (load) begin
      count_d = bcd_clamp(load_val);
      psc_d   = '0;
    end else if (go) begin
      if (tick_s) begin
        psc_d = '0;
        if (up) begin
          if (all_digits(count_q, 4'd9)) begin
            if (WRAP != 0) begin
              count_d = '0;
              step_d  = 1'b1;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q;
            end
          end else begin
            count_d = inc_s;
            step_d  = 1'b1;
            wrap_d  = (WRAP == 0) && all_digits(inc_s, 4'd9);
          end
        end else begin
          if (all_digits(count_q, 4'd0)) begin
            if (WRAP != 0) begin
              count_d = bcd_dec(count_q);
              step_d  = 1'b1;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q;
            end
          end else begin
            count_d = dec_s;
            step_d  = 1'b1;
            wrap_d  = (WRAP == 0) && all_digits(dec_s, 4'd0);
          end
        end
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end else begin
      psc_d = psc_q;
    end

    // Pause holds freeze state, and clr already forced it off above.
    if (!clr && go && lap) begin
      if (frozen_q) begin
        frozen_d = 1'b0;
      end else begin
        frozen_d = 1'b1;
        snap_d   = count_d;
      end
    end else begin
      frozen_d = frozen_d;
    end
  end

  // State registers with asynchronous reset to the idle, unfrozen zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q    <= '0;
      count_q  <= '0;
      snap_q   <= '0;
      frozen_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      psc_q    <= psc_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      frozen_q <= frozen_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count  = count_q;
  assign disp   = frozen_q ? snap_q : count_q;
  assign step   = step_q;
  assign wrap_p = wrap_q;
  assign tc     = up ? all_digits(count_q, 4'd9) : all_digits(count_q, 4'd0);

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Bench for bcd_counter_nd: a wrapping and a saturating 3-digit instance
// share stimulus and are compared to an integer-valued reference model.
module tb_bcd_counter_nd;

  localparam int DVSR = 4;
  localparam int MAXV = 999;

  logic        clk, rst_n, go, clr, up, load, lap;
  logic [11:0] load_val;
  logic [11:0] cnt_w, disp_w, cnt_s, disp_s;
  logic        step_w, tc_w, wrp_w, step_s, tc_s, wrp_s;

  int errors = 0;
  int checks = 0;

  // Reference state, index 0 = wrapping instance, 1 = saturating instance.
  int m_cnt[2], m_psc[2], m_snap[2];
  bit m_frz[2], m_stp[2], m_wrp[2];

  bcd_counter_nd #(.NDIG(3), .DVSR(DVSR), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .up(up), .load(load),
    .load_val(load_val), .lap(lap), .count(cnt_w), .disp(disp_w),
    .step(step_w), .tc(tc_w), .wrap_p(wrp_w));

  bcd_counter_nd #(.NDIG(3), .DVSR(DVSR), .WRAP(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .up(up), .load(load),
    .load_val(load_val), .lap(lap), .count(cnt_s), .disp(disp_s),
    .step(step_s), .tc(tc_s), .wrap_p(wrp_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] bcd(input int v);
    logic [3:0] d0, d1, d2;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    return {d2, d1, d0};
  endfunction

  function automatic int clampv(input logic [11:0] lv);
    int r, d;
    r = 0;
    for (int i = 2; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [11:0] m_disp(input int k);
    return m_frz[k] ? bcd(m_snap[k]) : bcd(m_cnt[k]);
  endfunction

  function automatic logic m_tc(input int k);
    return up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_psc[k] = 0; m_snap[k] = 0;
      m_frz[k] = 0; m_stp[k] = 0; m_wrp[k] = 0;
    end
  endtask

  // Advance the model by one clock using the integer value of the count.
  task automatic model_clk();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit wr;
      n  = m_cnt[k];
      wr = (k == 0);
      m_stp[k] = 0;
      m_wrp[k] = 0;
      if (clr) begin
        n = 0; m_psc[k] = 0; m_frz[k] = 0;
      end else if (load) begin
        n = clampv(load_val); m_psc[k] = 0;
      end else if (go) begin
        if (m_psc[k] == DVSR - 1) begin
          m_psc[k] = 0;
          if (up) begin
            if (n == MAXV) begin
              if (wr) begin n = 0; m_stp[k] = 1; m_wrp[k] = 1; end
            end else begin
              n = n + 1; m_stp[k] = 1; m_wrp[k] = !wr && (n == MAXV);
            end
          end else begin
            if (n == 0) begin
              if (wr) begin n = MAXV; m_stp[k] = 1; m_wrp[k] = 1; end
            end else begin
              n = n - 1; m_stp[k] = 1; m_wrp[k] = !wr && (n == 0);
            end
          end
        end else begin
          m_psc[k] = m_psc[k] + 1;
        end
      end
      if (!clr && go && lap) begin
        if (m_frz[k]) m_frz[k] = 0;
        else begin m_frz[k] = 1; m_snap[k] = n; end
      end
      m_cnt[k] = n;
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; lap = 1'b0;
    load_val = 12'h000;
    m_reset();
    #2;
    checks++;
    if (cnt_w !== 12'h000 || disp_w !== 12'h000 || step_w !== 1'b0 || wrp_w !== 1'b0 || tc_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_w: count=%h disp=%h step=%b wrap=%b tc=%b, required 000 000 0 0 0", cnt_w, disp_w, step_w, wrp_w, tc_w);
    end
    checks++;
    if (cnt_s !== 12'h000 || disp_s !== 12'h000 || step_s !== 1'b0 || wrp_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_s: count=%h disp=%h step=%b wrap=%b, required 000 000 0 0", cnt_s, disp_s, step_s, wrp_s);
    end
    up = 1'b0;
    #1;
    checks++;
    if (tc_w !== 1'b1 || tc_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: tc_w=%b tc_s=%b, required 1 1", tc_w, tc_s);
    end
    up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    int nsteps, nw, ns;
    go = 1'b1; up = 1'b1; nsteps = 0;
    for (int i = 0; i < 44; i++) begin
      clk_cycle();
      nsteps += int'(step_w);
      checks++;
      if (cnt_w !== bcd(m_cnt[0]) || step_w !== m_stp[0] || wrp_w !== 1'b0) begin
        errors++;
        $display("FAIL up_run cyc%0d: count=%h step=%b wrap=%b, required %h %b 0", i, cnt_w, step_w, wrp_w, bcd(m_cnt[0]), m_stp[0]);
      end
    end
    checks++;
    if (nsteps != 11 || cnt_w !== 12'h011) begin
      errors++;
      $display("FAIL up_rate: steps=%0d count=%h, required 11 011", nsteps, cnt_w);
    end
    load = 1'b1; load_val = 12'h998;
    clk_cycle();
    load = 1'b0;
    nw = 0; ns = 0;
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      nw += int'(wrp_w);
      ns += int'(wrp_s);
      checks++;
      if (cnt_w !== bcd(m_cnt[0]) || cnt_s !== bcd(m_cnt[1]) || wrp_w !== m_wrp[0] || wrp_s !== m_wrp[1]) begin
        errors++;
        $display("FAIL up_boundary cyc%0d: w=%h/%b s=%h/%b, required %h/%b %h/%b", i, cnt_w, wrp_w, cnt_s, wrp_s,
                 bcd(m_cnt[0]), m_wrp[0], bcd(m_cnt[1]), m_wrp[1]);
      end
    end
    checks++;
    if (nw != 1 || ns != 1 || cnt_w !== 12'h000 || cnt_s !== 12'h999 || tc_s !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap_sat: wraps_w=%0d wraps_s=%0d count_w=%h count_s=%h tc_s=%b, required 1 1 000 999 1", nw, ns, cnt_w, cnt_s, tc_s);
    end
  endtask

  task automatic test_down_saturate();
    int nwrap, late;
    load = 1'b1; load_val = 12'h102; up = 1'b0;
    clk_cycle();
    load = 1'b0;
    checks++;
    if (cnt_s !== 12'h102) begin
      errors++;
      $display("FAIL down_load: count=%h, required 102", cnt_s);
    end
    nwrap = 0; late = 0;
    for (int i = 0; i < 420; i++) begin
      clk_cycle();
      nwrap += int'(wrp_s);
      if (i >= 408) late += int'(step_s);
      checks++;
      if (cnt_s !== bcd(m_cnt[1]) || step_s !== m_stp[1] || wrp_s !== m_wrp[1] || cnt_w !== bcd(m_cnt[0]) || wrp_w !== m_wrp[0]) begin
        errors++;
        $display("FAIL down_run cyc%0d: s=%h/%b/%b w=%h/%b, required %h/%b/%b %h/%b", i, cnt_s, step_s, wrp_s, cnt_w, wrp_w,
                 bcd(m_cnt[1]), m_stp[1], m_wrp[1], bcd(m_cnt[0]), m_wrp[0]);
      end
    end
    checks++;
    if (nwrap != 1 || late != 0 || cnt_s !== 12'h000 || tc_s !== 1'b1) begin
      errors++;
      $display("FAIL down_sat: wraps=%0d late_steps=%0d count=%h tc=%b, required 1 0 000 1", nwrap, late, cnt_s, tc_s);
    end
  endtask

  task automatic test_pause();
    go = 1'b1; up = 1'b1;
    load = 1'b1; load_val = 12'h045;
    clk_cycle();
    load = 1'b0;
    clk_cycle();
    clk_cycle();
    go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      checks++;
      if (cnt_w !== 12'h045 || step_w !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold cyc%0d: count=%h step=%b, required 045 0", i, cnt_w, step_w);
      end
    end
    go = 1'b1;
    clk_cycle();
    checks++;
    if (cnt_w !== 12'h045 || step_w !== 1'b0) begin
      errors++;
      $display("FAIL resume_1: count=%h step=%b, required 045 0", cnt_w, step_w);
    end
    clk_cycle();
    checks++;
    if (cnt_w !== 12'h046 || step_w !== 1'b1) begin
      errors++;
      $display("FAIL resume_2: count=%h step=%b, required 046 1", cnt_w, step_w);
    end
  endtask

  task automatic test_load_clamp();
    go = 1'b1;
    load = 1'b1; load_val = 12'hA5F;
    clk_cycle();
    load = 1'b0;
    checks++;
    if (cnt_w !== 12'h959 || cnt_s !== 12'h959 || step_w !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count_w=%h count_s=%h step=%b, required 959 959 0", cnt_w, cnt_s, step_w);
    end
    clr = 1'b1; load = 1'b1; load_val = 12'h321;
    clk_cycle();
    clr = 1'b0; load = 1'b0;
    checks++;
    if (cnt_w !== 12'h000 || cnt_s !== 12'h000 || step_w !== 1'b0 || wrp_w !== 1'b0) begin
      errors++;
      $display("FAIL clr_over_load: count_w=%h count_s=%h step=%b wrap=%b, required 000 000 0 0", cnt_w, cnt_s, step_w, wrp_w);
    end
  endtask

  task automatic test_lap();
    int guard;
    go = 1'b1; up = 1'b1;
    clr = 1'b1;
    clk_cycle();
    clr = 1'b0;
    load = 1'b1; load_val = 12'h123;
    clk_cycle();
    load = 1'b0; lap = 1'b1;
    clk_cycle();
    lap = 1'b0;
    checks++;
    if (disp_w !== 12'h123) begin
      errors++;
      $display("FAIL lap_freeze: disp=%h, required 123", disp_w);
    end
    guard = 0;
    while (m_cnt[0] != 130 && guard < 40) begin
      clk_cycle();
      guard++;
      checks++;
      if (disp_w !== 12'h123 || cnt_w !== bcd(m_cnt[0])) begin
        errors++;
        $display("FAIL lap_hold: disp=%h count=%h, required 123 %h", disp_w, cnt_w, bcd(m_cnt[0]));
      end
    end
    checks++;
    if (cnt_w !== 12'h130 || disp_w !== 12'h123) begin
      errors++;
      $display("FAIL lap_reach: count=%h disp=%h, required 130 123", cnt_w, disp_w);
    end
    lap = 1'b1;
    clk_cycle();
    lap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (disp_w !== bcd(m_cnt[0]) || disp_s !== bcd(m_cnt[1])) begin
        errors++;
        $display("FAIL lap_release cyc%0d: disp_w=%h disp_s=%h, required %h %h", i, disp_w, disp_s, bcd(m_cnt[0]), bcd(m_cnt[1]));
      end
      clk_cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      go   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 31) == 0);
      lap  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) up = ~up;
      load_val = 12'($urandom);
      clk_cycle();
      for (int k = 0; k < 2; k++) begin
        logic [11:0] c, d;
        logic st, wp, t;
        c  = (k == 0) ? cnt_w  : cnt_s;
        d  = (k == 0) ? disp_w : disp_s;
        st = (k == 0) ? step_w : step_s;
        wp = (k == 0) ? wrp_w  : wrp_s;
        t  = (k == 0) ? tc_w   : tc_s;
        checks++;
        if (c !== bcd(m_cnt[k]) || d !== m_disp(k) || st !== m_stp[k] || wp !== m_wrp[k] || t !== m_tc(k)) begin
          errors++;
          $display("FAIL random cyc%0d inst%0d: count=%h disp=%h step=%b wrap=%b tc=%b, required %h %h %b %b %b",
                   i, k, c, d, st, wp, t, bcd(m_cnt[k]), m_disp(k), m_stp[k], m_wrp[k], m_tc(k));
        end
      end
    end
    clr = 1'b0; load = 1'b0; lap = 1'b0;
  endtask

  task automatic test_async_reset();
    go = 1'b1; up = 1'b1;
    clr = 1'b1;
    clk_cycle();
    clr = 1'b0;
    load = 1'b1; load_val = 12'h777;
    clk_cycle();
    load = 1'b0; lap = 1'b1;
    clk_cycle();
    lap = 1'b0;
    clk_cycle();
    checks++;
    if (disp_w !== 12'h777 || cnt_w !== 12'h777) begin
      errors++;
      $display("FAIL pre_reset: count=%h disp=%h, required 777 777", cnt_w, disp_w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt_w !== 12'h000 || disp_w !== 12'h000 || cnt_s !== 12'h000 || disp_s !== 12'h000 || step_w !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count_w=%h disp_w=%h count_s=%h disp_s=%h step=%b, required 000 000 000 000 0",
               cnt_w, disp_w, cnt_s, disp_s, step_w);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      checks++;
      if (cnt_w !== bcd(m_cnt[0]) || disp_w !== bcd(m_cnt[0]) || step_w !== m_stp[0]) begin
        errors++;
        $display("FAIL post_reset cyc%0d: count=%h disp=%h step=%b, required %h %h %b", i, cnt_w, disp_w, step_w,
                 bcd(m_cnt[0]), bcd(m_cnt[0]), m_stp[0]);
      end
    end
    checks++;
    if (cnt_w !== 12'h002) begin
      errors++;
      $display("FAIL post_reset_count: count=%h, required 002", cnt_w);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_saturate();
    test_pause();
    test_load_clamp();
    test_lap();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
